// File: rtl/ram_sync.sv
// Single-port synchronous RAM with valid/ready requests and a zero-fill sweeper.
// Define RAM_OUT_REG_EN to add a second read-data register (read latency 2).
module ram_sync #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  OPCODE,
  input  logic [ADDR_WIDTH-1:0] ADDRESS,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  CLEAR,
  output logic                  RESP_VALID,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  BUSY
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  typedef enum logic {
    SWEEP,
    READY
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rd_en;

  logic                  rvld_q, rvld_d;
  logic [DATA_WIDTH-1:0] rdat_q, rdat_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    REQ_READY = 1'b0;
    BUSY      = 1'b0;
    we        = 1'b0;
    waddr     = ADDRESS;
    wdata     = DATA_IN;
    rd_en     = 1'b0;
    unique case (state_q)
      SWEEP: begin
        BUSY  = 1'b1;
        we    = 1'b1;
        waddr = cnt_q;
        wdata = '0;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = READY;
        end
      end
      READY: begin
        if (CLEAR) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end else begin
          REQ_READY = 1'b1;
          if (REQ_VALID) begin
            we    = OPCODE;
            rd_en = !OPCODE;
          end
        end
      end
      default: begin
        state_d = SWEEP;
        cnt_d   = '0;
      end
    endcase
  end

  // Array has no reset; contents are defined by the first sweep.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rvld_d = rd_en;
    rdat_d = rdat_q;
    if (rd_en) begin
      rdat_d = mem_q[ADDRESS];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rvld_q <= 1'b0;
      rdat_q <= '0;
    end else begin
      rvld_q <= rvld_d;
      rdat_q <= rdat_d;
    end
  end

`ifdef RAM_OUT_REG_EN
  logic                  ovld_q, ovld_d;
  logic [DATA_WIDTH-1:0] odat_q, odat_d;

  always_comb begin
    ovld_d = rvld_q;
    odat_d = odat_q;
    if (rvld_q) begin
      odat_d = rdat_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ovld_q <= 1'b0;
      odat_q <= '0;
    end else begin
      ovld_q <= ovld_d;
      odat_q <= odat_d;
    end
  end

  assign RESP_VALID = ovld_q;
  assign DATA_OUT   = odat_q;
`else
  assign RESP_VALID = rvld_q;
  assign DATA_OUT   = rdat_q;
`endif

endmodule

// File: tb/tb_ram_sync.sv
// Scoreboard bench for ram_sync: default 16x8 instance plus a 64x32 instance.
// Expected read data and response cycle are queued at accept, checked by monitors.
module tb_ram_sync;

`ifdef RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t m0e, m1e;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n;

  logic       CLK = 1'b0;
  logic       RST, REQ_VALID, OPCODE, CLEAR;
  logic [3:0] ADDRESS;
  logic [7:0] DATA_IN;
  logic       REQ_READY, RESP_VALID, BUSY;
  logic [7:0] DATA_OUT;

  logic        rst1, v1, op1, clr1;
  logic [5:0]  a1;
  logic [31:0] d1;
  logic        rdy1, rv1, busy1;
  logic [31:0] do1;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  ram_sync #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut0 (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID),
    .REQ_READY(REQ_READY), .OPCODE(OPCODE),
    .ADDRESS(ADDRESS), .DATA_IN(DATA_IN),
    .CLEAR(CLEAR), .RESP_VALID(RESP_VALID),
    .DATA_OUT(DATA_OUT), .BUSY(BUSY)
  );

  ram_sync #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) dut1 (
    .CLK(CLK), .RST(rst1), .REQ_VALID(v1),
    .REQ_READY(rdy1), .OPCODE(op1),
    .ADDRESS(a1), .DATA_IN(d1),
    .CLEAR(clr1), .RESP_VALID(rv1),
    .DATA_OUT(do1), .BUSY(busy1)
  );

  function automatic void check(string name,
                                logic [31:0] act,
                                logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h",
               name, act, exp);
    end
  endfunction

  always @(negedge CLK) begin
    if (RESP_VALID) begin
      if (sb0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp0_unexpected actual=%h expected=none",
                 DATA_OUT);
      end else begin
        m0e = sb0.pop_front();
        check("resp0_data", {24'h0, DATA_OUT}, m0e.data);
        check("resp0_cycle", cyc, m0e.cyc);
      end
    end
  end

  always @(negedge CLK) begin
    if (rv1) begin
      if (sb1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp1_unexpected actual=%h expected=none",
                 do1);
      end else begin
        m1e = sb1.pop_front();
        check("resp1_data", do1, m1e.data);
        check("resp1_cycle", cyc, m1e.cyc);
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the accept edge.
  task automatic req0(input logic op, input logic [3:0] a,
                      input logic [7:0] d);
    int k;
    REQ_VALID = 1'b1;
    OPCODE    = op;
    ADDRESS   = a;
    DATA_IN   = d;
    for (k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (REQ_READY) break;
    end
    if (k == 100) begin
      check("req0_timeout", 32'(k), 32'd0);
    end
    @(posedge CLK);
    #1;
    if (!op) sb0.push_back('{32'(d), cyc + LAT - 1});
  endtask

  task automatic req1(input logic op, input logic [5:0] a,
                      input logic [31:0] d);
    int k;
    v1  = 1'b1;
    op1 = op;
    a1  = a;
    d1  = d;
    for (k = 0; k < 200; k++) begin
      @(negedge CLK);
      if (rdy1) break;
    end
    if (k == 200) begin
      check("req1_timeout", 32'(k), 32'd0);
    end
    @(posedge CLK);
    #1;
    if (!op) sb1.push_back('{d, cyc + LAT - 1});
  endtask

  task automatic idle(input int c);
    REQ_VALID = 1'b0;
    v1        = 1'b0;
    repeat (c) @(posedge CLK);
    #1;
  endtask

  task automatic count_ready0(output int cnt);
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      if (REQ_READY) break;
      if (!BUSY) check("busy0_during_init", 32'(BUSY), 32'd1);
      cnt++;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic count_ready1(output int cnt);
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      if (rdy1) break;
      cnt++;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic count_busy0(output int cnt);
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      if (!BUSY) break;
      if (REQ_READY) check("ready0_in_sweep", 32'(REQ_READY), 32'd0);
      cnt++;
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; REQ_VALID = 1'b0; OPCODE = 1'b0;
    ADDRESS = '0; DATA_IN = '0; CLEAR = 1'b0;
    rst1 = 1'b1; v1 = 1'b0; op1 = 1'b0;
    a1 = '0; d1 = '0; clr1 = 1'b0;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_ready", 32'(REQ_READY), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd1);
    check("rst_rvalid", 32'(RESP_VALID), 32'd0);
    check("rst_dout", 32'(DATA_OUT), 32'd0);

    OPCODE = 1'b0; ADDRESS = 4'd5; REQ_VALID = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    count_ready0(n);
    check("init_cycles", n, 16);
    sb0.push_back('{32'h0, cyc + LAT - 1});
    REQ_VALID = 1'b0;
    idle(1);

    req0(1'b1, 4'd3, 8'hA5);
    req0(1'b1, 4'd15, 8'h3C);
    req0(1'b0, 4'd3, 8'hA5);
    req0(1'b0, 4'd15, 8'h3C);
    req0(1'b0, 4'd3, 8'hA5);
    idle(3);
    check("dout_hold", 32'(DATA_OUT), 32'hA5);
    check("rvalid_low", 32'(RESP_VALID), 32'd0);

    req0(1'b1, 4'd9, 8'h77);
    req0(1'b0, 4'd9, 8'h77);
    idle(2);

    for (int i = 0; i < 16; i++) req0(1'b1, 4'(i), 8'h80 | 8'(i));
    for (int i = 0; i < 16; i++) req0(1'b0, 4'(i), 8'h80 | 8'(i));

    req0(1'b0, 4'd4, 8'h84);
    REQ_VALID = 1'b0;
    CLEAR = 1'b1;
    @(negedge CLK);
    check("clear_ready", 32'(REQ_READY), 32'd0);
    @(posedge CLK);
    #1 CLEAR = 1'b0;
    count_busy0(n);
    check("sweep_after_read", n, 16);

    for (int i = 0; i < 16; i++) req0(1'b1, 4'(i), 8'h40 | 8'(i));
    OPCODE = 1'b0; ADDRESS = 4'd2; REQ_VALID = 1'b1; CLEAR = 1'b1;
    @(negedge CLK);
    check("clear_req_ready", 32'(REQ_READY), 32'd0);
    @(posedge CLK);
    #1 REQ_VALID = 1'b0; CLEAR = 1'b0;
    count_busy0(n);
    check("sweep_cycles", n, 16);
    for (int i = 0; i < 16; i++) req0(1'b0, 4'(i), 8'h00);
    idle(2);

    CLEAR = 1'b1;
    @(posedge CLK);
    #1 CLEAR = 1'b0;
    repeat (7) @(posedge CLK);
    #1 RST = 1'b1;
    #2;
    check("rst7_busy", 32'(BUSY), 32'd1);
    check("rst7_ready", 32'(REQ_READY), 32'd0);
    @(posedge CLK);
    #1 RST = 1'b0;
    count_ready0(n);
    check("rst7_restart_cycles", n, 16);

    req0(1'b1, 4'd9, 8'h55);
    req0(1'b0, 4'd9, 8'h55);
    REQ_VALID = 1'b0;
    RST = 1'b1;
    sb0.delete();
    #1;
    check("drop_rvalid", 32'(RESP_VALID), 32'd0);
    check("drop_dout", 32'(DATA_OUT), 32'd0);
    @(posedge CLK);
    #1 RST = 1'b0;
    count_ready0(n);
    check("drop_restart_cycles", n, 16);
    req0(1'b0, 4'd9, 8'h00);
    idle(3);

    @(posedge CLK);
    #1 rst1 = 1'b0;
    count_ready1(n);
    check("init64_cycles", n, 64);
    req1(1'b1, 6'd63, 32'hDEADBEEF);
    req1(1'b1, 6'd15, 32'h0000F00D);
    req1(1'b0, 6'd63, 32'hDEADBEEF);
    req1(1'b0, 6'd15, 32'h0000F00D);
    req1(1'b0, 6'd0, 32'h00000000);
    req1(1'b0, 6'd47, 32'h00000000);
    idle(4);

    check("sb0_empty", 32'(sb0.size()), 32'd0);
    check("sb1_empty", 32'(sb1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_sync.md
# ram_sync

Parametrised, single-port, synchronous RAM with a valid/ready request interface, registered read data and a hardware clear sequencer. It replaces the fixed 16x8 combinational RAM as the general data store for the datapath. After reset, or on command, it zero-fills every word before it accepts traffic.

## Interface

Parameters:
- DATA_WIDTH, 8, word width in bits (>= 1)
- ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH words

Ports:
- CLK  in  1  clock; all state changes on the rising edge
- RST  in  1  reset, asynchronous, active-high
- REQ_VALID  in  1  request present
- REQ_READY  out  1  request can be accepted this cycle
- OPCODE  in  1  0 = read, 1 = write
- ADDRESS  in  ADDR_WIDTH  word address
- DATA_IN  in  DATA_WIDTH  write data
- CLEAR  in  1  start a zero-fill sweep; level-sampled while READY
- RESP_VALID  out  1  DATA_OUT holds a new read result; one-cycle pulse per read
- DATA_OUT  out  DATA_WIDTH  read data; holds last result between reads
- BUSY  out  1  clear sweep in progress

## Operation

- FSM states: SWEEP and READY. RST forces SWEEP with sweep counter = 0.
- SWEEP:
  - writes 0 to address counter, one word per cycle;
  - REQ_READY = 0, BUSY = 1;
  - after writing DEPTH-1, goes to READY on the next edge;
  - the sweep takes exactly DEPTH cycles.
- READY: BUSY = 0, REQ_READY = !CLEAR (combinational on CLEAR only).
- Accept = REQ_VALID && REQ_READY at a rising edge.
  - Write accept: mem[ADDRESS] <= DATA_IN at that edge.
  - Read accept: mem[ADDRESS] is captured into the output path at that edge.
- CLEAR high in READY: go to SWEEP, counter = 0. No request is accepted in that cycle.
- CLEAR is ignored during SWEEP; the sweep does not restart.
- A read accepted before a sweep starts still delivers its response, with the pre-clear data.
- REQ_VALID with REQ_READY = 0: the request is not consumed, and nothing changes.
- The block does not check that inputs stay stable; the requester holds them until accepted.
- Reset values: REQ_READY 0, BUSY 1, RESP_VALID 0, DATA_OUT 0. Memory contents are undefined until the first sweep completes.
- RST asserted mid-sweep or mid-read:
  - the sweep restarts from address 0;
  - any in-flight response is dropped (RESP_VALID 0).

## Timing

- Write latency: 0. Data is stored at the accept edge.
- Read latency (macro off): read accepted at edge N gives RESP_VALID = 1 and DATA_OUT valid after edge N; RESP_VALID falls after edge N+1 unless another read is accepted.
- Throughput: one request per cycle, reads and writes in any order.
- Write at edge N, then read of the same address accepted at edge N+1: returns the new data.
- First accept after reset release: no earlier than DEPTH cycles after the first edge with RST low.

## Configuration

- RAM_OUT_REG_EN defined:
  - adds an output register stage, so read latency becomes 2;
  - RESP_VALID and DATA_OUT appear after edge N+1 for a read accepted at edge N;
  - throughput stays one per cycle;
  - the pipeline register resets to 0.
- Undefined: latency 1 as specified above.
- The interface and all other behaviour are identical in both configurations.

## Test plan

- Reset, then hold REQ_VALID with a read of address 5 → REQ_READY stays 0 for 16 cycles (BUSY 1); then the read is accepted, and DATA_OUT = 0x00 with RESP_VALID = 1 at latency 1 (2 with macro).
- Write 0xA5 to address 3 and 0x3C to address 15; read 3, 15, 3 back-to-back → three consecutive RESP_VALID pulses with 0xA5, 0x3C, 0xA5; DATA_OUT holds 0xA5 afterwards.
- Write 0x77 to address 9 at edge N, read 9 at edge N+1 → 0x77.
- Fill all 16 words with nonzero data; pulse CLEAR together with REQ_VALID → that request is not accepted; BUSY = 1 for 16 cycles; all later reads return 0x00.
- Issue a read, then assert CLEAR the next cycle → the read response is delivered with the pre-clear data. Separately, assert RST at sweep address 7 → the sweep restarts at 0 and takes a full 16 cycles after release.
- Parameter sweep: DATA_WIDTH = 32, ADDR_WIDTH = 6 → 64-cycle init; write/read of 0xDEADBEEF to address 63 matches; address wrap-around is not aliased.
